// File: rtl/shift_add_pkg.sv
// ============================================================================
// shift_add_pkg : shared state encoding and sizing helper for the multiplier
// Revision 1.0
// ============================================================================
`default_nettype none

package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/carry_ripple_adder.sv
// ============================================================================
// carry_ripple_adder : N-bit ripple-carry adder with carry-in and carry-out
// Revision 1.0
// ============================================================================
`default_nettype none

module carry_ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// shift_add_multiplier : sequential unsigned WIDTH x WIDTH shift-and-add
// multiplier. Optional macro SHIFT_ADD_EARLY_EXIT_EN finishes early once the
// unconsumed multiplier bits are all zero.  Revision 1.0
// ============================================================================
`default_nettype none

module shift_add_multiplier
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 busy_q, done_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;

  assign addend = lo_q[0] ? mcand_q : '0;

  carry_ripple_adder #(.N(WIDTH)) u_adder (
    .a    (hi_q),
    .b    (addend),
    .cin  (1'b0),
    .s    (sum[WIDTH-1:0]),
    .cout (sum[WIDTH])
  );

`ifdef SHIFT_ADD_EARLY_EXIT_EN
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] rem_mask;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    rem       = LAST - count_q;
    rem_mask  = {WIDTH{1'b1}} >> (CNT_W'(WIDTH) - rem);
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = multiplicand;
          hi_d    = '0;
          lo_d    = multiplier;
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Carry-out lands in hi[WIDTH-1]; the consumed multiplier bit falls off lo[0].
        hi_d    = sum[WIDTH:1];
        lo_d    = {sum[0], lo_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) begin
          product_d = {hi_d, lo_d};
          state_d   = DONE;
        end
`ifdef SHIFT_ADD_EARLY_EXIT_EN
        // Unconsumed multiplier bits sit at the bottom of lo; if all zero the
        // partial product is final once they are shifted out.
        else if ((rem != '0) && ((lo_d & rem_mask) == '0)) begin
          product_d = {hi_d, lo_d} >> rem;
          state_d   = DONE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      count_q   <= count_d;
      product_q <= product_d;
      busy_q    <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

`default_nettype wire
